// File: rtl/scope_capture_buffer.sv
// Ping-pong oscilloscope capture: circular pre-trigger history, edge/auto trigger, swap on frame_sync.
// Optional SCOPE_DECIMATE_EN adds a decim port that accepts every (decim+1)-th valid sample.
module scope_capture_buffer #(
    parameter int SAMPLE_W     = 9,
    parameter int DEPTH        = 640,
    parameter int ADDR_W       = 10,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    input  logic [1:0]          trig_mode,
    input  logic [ADDR_W-1:0]   pretrig,
    input  logic                arm,
    input  logic                frame_sync,
`ifdef SCOPE_DECIMATE_EN
    input  logic [7:0]          decim,
`endif
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                triggered,
    output logic                capture_done,
    output logic                forced
);
    localparam logic [2:0] ST_ARM  = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_POST = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_IDLE = 3'd4;
    localparam logic [1:0] MODE_AUTO   = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_STOP   = 2'd3;
    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PRE_MAX  = ADDR_W'(DEPTH - 1);
    localparam logic [TW-1:0]     AUTO_MAX = TW'(AUTO_TIMEOUT);

    // Operands are always < DEPTH, so one conditional subtract suffices.
    function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [CW-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= DEPTH_C) s = s - DEPTH_C;
        return s[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] mod_sub(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [CW-1:0] s;
        s = {1'b0, a} + DEPTH_C - {1'b0, b};
        if (s >= DEPTH_C) s = s - DEPTH_C;
        return s[ADDR_W-1:0];
    endfunction

    logic [2:0]          r_state;
    logic                r_cap_buf, r_arm_first, r_prev_valid, r_forced_flag;
    logic                r_triggered, r_capture_done, r_forced;
    logic [ADDR_W-1:0]   r_wr_ptr, r_disp_start, r_trig_ptr, r_pre;
    logic [1:0]          r_mode;
    logic [CW-1:0]       r_cnt;
    logic [TW-1:0]       r_auto_cnt;
    logic [SAMPLE_W-1:0] r_prev, r_rd_data;
    logic [SAMPLE_W-1:0] r_mem0 [0:DEPTH-1];
    logic [SAMPLE_W-1:0] r_mem1 [0:DEPTH-1];

    logic [ADDR_W-1:0]   w_pre_in, w_pre, w_phys;
    logic [1:0]          w_mode;
    logic [CW-1:0]       w_post_tgt;
    logic                w_acc, w_capturing, w_wr, w_cross, w_real, w_force, w_fire;

    // Latched settings take effect in the very first ARM cycle, before the register updates.
    assign w_pre_in    = (pretrig > PRE_MAX) ? PRE_MAX : pretrig;
    assign w_pre       = r_arm_first ? w_pre_in : r_pre;
    assign w_mode      = r_arm_first ? trig_mode : r_mode;
    assign w_post_tgt  = DEPTH_C - {1'b0, w_pre};
    assign w_capturing = (r_state == ST_ARM) || (r_state == ST_POST) ||
                         ((r_state == ST_WAIT) && (w_mode != MODE_STOP));
    assign w_wr        = w_acc && w_capturing;
    assign w_real      = r_prev_valid && w_cross;
    assign w_force     = (w_mode == MODE_AUTO) && (r_auto_cnt == AUTO_MAX);
    assign w_fire      = (r_state == ST_WAIT) && w_wr && (w_real || w_force);
    assign w_phys      = mod_add(r_disp_start, rd_addr);

`ifdef SCOPE_DECIMATE_EN
    logic [7:0] r_decim, r_dec_cnt, w_decim;
    assign w_decim = r_arm_first ? decim : r_decim;
    assign w_acc   = sample_valid && (r_dec_cnt == 8'd0);
`else
    assign w_acc   = sample_valid;
`endif

    // Edge detect against the previous accepted sample.
    always_comb begin
        if (trig_rising) begin
            w_cross = (r_prev < trig_level) && (sample_in >= trig_level);
        end else begin
            w_cross = (r_prev >= trig_level) && (sample_in < trig_level);
        end
    end

    task automatic enter_arm();
        r_state       <= ST_ARM;
        r_arm_first   <= 1'b1;
        r_cnt         <= {CW{1'b0}};
        r_auto_cnt    <= {TW{1'b0}};
        r_prev_valid  <= 1'b0;
        r_forced_flag <= 1'b0;
        r_wr_ptr      <= {ADDR_W{1'b0}};
`ifdef SCOPE_DECIMATE_EN
        r_dec_cnt     <= 8'd0;
`endif
    endtask

    // Capture control FSM, pointers and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_ARM;
            r_cap_buf      <= 1'b1;
            r_arm_first    <= 1'b1;
            r_prev_valid   <= 1'b0;
            r_forced_flag  <= 1'b0;
            r_triggered    <= 1'b0;
            r_capture_done <= 1'b0;
            r_forced       <= 1'b0;
            r_wr_ptr       <= {ADDR_W{1'b0}};
            r_disp_start   <= {ADDR_W{1'b0}};
            r_trig_ptr     <= {ADDR_W{1'b0}};
            r_pre          <= {ADDR_W{1'b0}};
            r_mode         <= 2'd0;
            r_cnt          <= {CW{1'b0}};
            r_auto_cnt     <= {TW{1'b0}};
            r_prev         <= {SAMPLE_W{1'b0}};
`ifdef SCOPE_DECIMATE_EN
            r_decim        <= 8'd0;
            r_dec_cnt      <= 8'd0;
`endif
        end else begin
            if (w_wr) begin
                r_wr_ptr     <= mod_add(r_wr_ptr, ADDR_ONE);
                r_prev       <= sample_in;
                r_prev_valid <= 1'b1;
            end
`ifdef SCOPE_DECIMATE_EN
            if (sample_valid && w_capturing) begin
                r_dec_cnt <= (r_dec_cnt == w_decim) ? 8'd0 : r_dec_cnt + 8'd1;
            end
`endif
            case (r_state)
                ST_ARM: begin
                    if (r_arm_first) begin
                        r_arm_first <= 1'b0;
                        r_mode      <= trig_mode;
                        r_pre       <= w_pre_in;
`ifdef SCOPE_DECIMATE_EN
                        r_decim     <= decim;
`endif
                    end
                    if (w_pre == {ADDR_W{1'b0}}) begin
                        r_state <= ST_WAIT;
                    end else if (w_wr) begin
                        if (r_cnt + CNT_ONE == {1'b0, w_pre}) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= {CW{1'b0}};
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_mode == MODE_STOP) begin
                        if (trig_mode != MODE_STOP) enter_arm();
                    end else if (w_fire) begin
                        r_trig_ptr    <= r_wr_ptr;
                        r_triggered   <= 1'b1;
                        r_forced_flag <= !w_real;
                        // The trigger sample is post sample 1; it may also be the last.
                        if (w_post_tgt == CNT_ONE) begin
                            r_state        <= ST_DONE;
                            r_capture_done <= 1'b1;
                        end else begin
                            r_state <= ST_POST;
                            r_cnt   <= CNT_ONE;
                        end
                    end else if (w_wr && (r_auto_cnt != AUTO_MAX)) begin
                        r_auto_cnt <= r_auto_cnt + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                ST_POST: begin
                    if (w_wr) begin
                        if (r_cnt + CNT_ONE == w_post_tgt) begin
                            r_state        <= ST_DONE;
                            r_capture_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_sync) begin
                        r_cap_buf      <= ~r_cap_buf;
                        r_disp_start   <= mod_sub(r_trig_ptr, r_pre);
                        r_forced       <= r_forced_flag;
                        r_triggered    <= 1'b0;
                        r_capture_done <= 1'b0;
                        if (r_mode == MODE_SINGLE) r_state <= ST_IDLE;
                        else enter_arm();
                    end
                end
                ST_IDLE: begin
                    if (arm) enter_arm();
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end

    // Sample storage; the capture buffer is the one the display is not reading.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            if (r_cap_buf) r_mem1[r_wr_ptr] <= sample_in;
            else           r_mem0[r_wr_ptr] <= sample_in;
        end
    end

    // Registered display read by logical column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= {SAMPLE_W{1'b0}};
        end else if ({1'b0, rd_addr} >= DEPTH_C) begin
            r_rd_data <= {SAMPLE_W{1'b0}};
        end else if (r_cap_buf) begin
            r_rd_data <= r_mem0[w_phys];
        end else begin
            r_rd_data <= r_mem1[w_phys];
        end
    end

    assign rd_data      = r_rd_data;
    assign triggered    = r_triggered;
    assign capture_done = r_capture_done;
    assign forced       = r_forced;
endmodule

// File: tb/tb_scope_capture_buffer.sv
// Self-checking bench for scope_capture_buffer: capture scenarios plus table-driven display reads.
module tb_scope_capture_buffer;
    localparam int SW = 9;
    localparam int DEPTH = 640;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sample_in = 9'd0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] trig_level = 9'd0;
    logic          trig_rising = 1'b1;
    logic [1:0]    trig_mode = 2'd0;
    logic [AW-1:0] pretrig = 10'd0;
    logic          arm = 1'b0;
    logic          frame_sync = 1'b0;
    logic [7:0]    decim = 8'd0;
    logic [AW-1:0] rd_addr = 10'd0;
    logic [SW-1:0] rd_data;
    logic          triggered, capture_done, forced;

    always #5 clk = ~clk;

    scope_capture_buffer #(.SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .AUTO_TIMEOUT(4096)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_level(trig_level), .trig_rising(trig_rising), .trig_mode(trig_mode),
        .pretrig(pretrig), .arm(arm), .frame_sync(frame_sync),
`ifdef SCOPE_DECIMATE_EN
        .decim(decim),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data), .triggered(triggered),
        .capture_done(capture_done), .forced(forced)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[$];
    rd_vec_t sb_q[$];
    int n_pass = 0;
    int n_total = 0;
    int n_rises = 0;
    logic cd_q = 1'b0;
    int fed;
    int r0;

    always @(negedge clk) begin
        if (capture_done && !cd_q) n_rises <= n_rises + 1;
        cd_q <= capture_done;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] stim(input int kind, input int idx);
        if (kind == 0) return SW'(idx % 512);
        if (kind == 1) return (((idx / 32) % 2) == 0) ? 9'd250 : 9'd150;
        return 9'd50;
    endfunction

    task automatic cfg(input logic [1:0] m, input logic r, input logic [SW-1:0] lv, input logic [AW-1:0] p);
        trig_mode = m; trig_rising = r; trig_level = lv; pretrig = p;
    endtask

    // Feed samples until capture_done; fed = samples driven, -1 if the budget expired.
    task automatic feed(input int kind, input int budget, input int fs_idx, output int n);
        int idx = 0;
        n = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            frame_sync = 1'b0;
            if (capture_done) begin
                n = idx;
                break;
            end
            sample_in = stim(kind, idx);
            sample_valid = 1'b1;
            if (idx == fs_idx) frame_sync = 1'b1;
            idx++;
        end
        sample_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic feed_n(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            sample_in = stim(kind, i);
            sample_valid = 1'b1;
        end
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_fs();
        tick(); frame_sync = 1'b1;
        tick(); frame_sync = 1'b0;
    endtask

    task automatic pulse_arm();
        tick(); arm = 1'b1;
        tick(); arm = 1'b0;
    endtask

    task automatic add(input int a, input int e);
        rd_vec_t v;
        v.addr = AW'(a);
        v.exp  = SW'(e);
        vecs.push_back(v);
    endtask

    // Drive each table address; compare the returned data one cycle later.
    task automatic run_reads(input string tag);
        rd_vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            if (sb_q.size() > 0) begin
                v = sb_q.pop_front();
                check($sformatf("%s_rd%0d", tag, v.addr), rd_data, v.exp);
            end
            rd_addr = vecs[i].addr;
            sb_q.push_back(vecs[i]);
        end
        tick();
        v = sb_q.pop_front();
        check($sformatf("%s_rd%0d", tag, v.addr), rd_data, v.exp);
        vecs.delete();
        rd_addr = 10'd0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        cfg(2'd0, 1'b1, 9'd100, 10'd10);
        tick(); tick();
        check("rst_rd_data", rd_data, 0);
        check("rst_triggered", triggered, 0);
        check("rst_capture_done", capture_done, 0);
        check("rst_forced", forced, 0);
        reset = 1'b0;

        // Rising ramp, pretrig 10: trigger on sample 100, 630 post samples.
        feed(0, 2000, -1, fed);
        check("t1_fed", fed, 730);
        check("t1_triggered", triggered, 1);
        check("t1_done", capture_done, 1);
        cfg(2'd0, 1'b0, 9'd200, 10'd0);
        pulse_fs();
        check("t1_done_clr", capture_done, 0);
        check("t1_trig_clr", triggered, 0);
        check("t1_forced", forced, 0);
        add(0, 90); add(10, 100); add(639, stim(0, 729)); add(320, stim(0, 410));
        add(500, stim(0, 590)); add(640, 0); add(1023, 0);
        run_reads("t1");

        // Falling square, pretrig 0.
        r0 = n_rises;
        feed(1, 2000, -1, fed);
        check("t2_fed", fed, 672);
        cfg(2'd1, 1'b1, 9'd100, 10'd10);
        pulse_fs();
        repeat (3) tick();
        check("t2_done_once", n_rises - r0, 1);
        add(0, 150); add(31, 150); add(32, 250); add(639, stim(1, 32 + 639));
        run_reads("t2");

        // Auto mode, constant 50: forced trigger after 4096 waiting samples.
        feed(2, 6000, -1, fed);
        check("t3_fed", fed, 4736);
        check("t3_triggered", triggered, 1);
        cfg(2'd2, 1'b1, 9'd100, 10'd10);
        pulse_fs();
        check("t3_forced", forced, 1);
        add(0, 50); add(100, 50); add(639, 50);
        run_reads("t3");

        // Single mode: swap, then idle until arm.
        feed(0, 2000, -1, fed);
        check("t4_fed", fed, 730);
        cfg(2'd0, 1'b0, 9'd200, 10'd5);
        pulse_fs();
        check("t4_forced", forced, 0);
        add(0, 90); add(639, stim(0, 729));
        run_reads("t4");
        feed_n(0, 1200);
        check("t4_idle_done", capture_done, 0);
        check("t4_idle_trig", triggered, 0);
        add(0, 90);
        run_reads("t4idle");
        pulse_arm();
        feed(1, 2000, -1, fed);
        check("t5_fed", fed, 667);
        cfg(2'd0, 1'b1, 9'd100, 10'd10);
        pulse_fs();
        add(0, 250); add(4, 250); add(5, 150);
        run_reads("t5");

        // frame_sync coincident with the last write is not honoured.
        feed(0, 2000, 729, fed);
        check("t6_fed", fed, 730);
        repeat (3) tick();
        check("t6_no_swap", capture_done, 1);
        add(0, 250);
        run_reads("t6pre");
        pulse_fs();
        check("t6_done_clr", capture_done, 0);
        add(0, 90);
        run_reads("t6post");

        // Asynchronous reset mid-POST.
        feed_n(0, 300);
        check("t7_mid_post", triggered, 1);
        check("t7_rd_before", rd_data, 90);
        #3 reset = 1'b1;
        #1;
        check("t7_rst_rd", rd_data, 0);
        check("t7_rst_trig", triggered, 0);
        check("t7_rst_done", capture_done, 0);
        check("t7_rst_forced", forced, 0);
        tick();
        reset = 1'b0;
        feed(0, 2000, -1, fed);
        check("t7_fed", fed, 730);
        decim = 8'd3;
        pulse_fs();
        add(0, 90); add(10, 100);
        run_reads("t7");

`ifdef SCOPE_DECIMATE_EN
        // Every 4th sample accepted: display steps by 4.
        feed(0, 4000, -1, fed);
        check("t8_fed", fed, 2617);
        pulse_fs();
        add(0, 60); add(1, 64); add(2, 68); add(10, 100); add(639, stim(0, 2616));
        run_reads("t8");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
